// File: rtl/tcp_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tcp_tx_ctrl
//
// Control half of the TCP transmit protocol-calculation stage. One scheduler
// request is in flight at a time. For each flow the controller:
//   1. accepts the scheduler request and strobes the datapath to latch it,
//   2. issues four per-flow memory reads (tail pointer, tx state, rx state,
//      flow tuple) and waits for every grant,
//   3. joins the three state responses (consumed together) and independently
//      consumes the tuple response,
//   4. strobes the datapath calculation, then asks the datapath whether a
//      packet is warranted,
//   5. if so, emits the packet descriptor and writes back the tx state,
//   6. returns an update command to the scheduler.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   sched_tx_req_val/rdy          scheduler request handshake
//   *_rd_req_val/rdy              memory read requests (tail, tx, rx, tuple)
//   *_rd_resp_val/rdy             memory read responses
//   next_tx_state_wr_req_val/rdy  tx-state writeback
//   tx_pkt_val/rdy                packet descriptor to the packet builder
//   sched_tx_update_val/rdy       update command back to the scheduler
//   ctrl_datap_store_*            datapath latch strobes
//   datap_ctrl_produce_pkt        datapath decision: send a packet
//
// Optional feature (macro TCP_TX_CTRL_PERF_CNT_EN)
//   Adds perf_pkts_sent, perf_pkts_suppressed and perf_stall_cycles, each
//   CNT_W bits wide, wrapping, cleared by reset.
// -----------------------------------------------------------------------------
module tcp_tx_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,

    input  logic sched_tx_req_val,
    output logic sched_tx_req_rdy,

    output logic tail_ptr_rd_req_val,
    input  logic tail_ptr_rd_req_rdy,
    input  logic tail_ptr_rd_resp_val,
    output logic tail_ptr_rd_resp_rdy,

    output logic curr_tx_state_rd_req_val,
    input  logic curr_tx_state_rd_req_rdy,
    input  logic curr_tx_state_rd_resp_val,
    output logic curr_tx_state_rd_resp_rdy,

    output logic rx_state_rd_req_val,
    input  logic rx_state_rd_req_rdy,
    input  logic rx_state_rd_resp_val,
    output logic rx_state_rd_resp_rdy,

    output logic tuple_rd_req_val,
    input  logic tuple_rd_req_rdy,
    input  logic tuple_rd_resp_val,
    output logic tuple_rd_resp_rdy,

    output logic next_tx_state_wr_req_val,
    input  logic next_tx_state_wr_req_rdy,

    output logic tx_pkt_val,
    input  logic tx_pkt_rdy,

    output logic sched_tx_update_val,
    input  logic sched_tx_update_rdy,

    output logic ctrl_datap_store_flowid,
    output logic ctrl_datap_store_state,
    output logic ctrl_datap_store_tuple,
    output logic ctrl_datap_store_calc,
    input  logic datap_ctrl_produce_pkt
`ifdef TCP_TX_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_pkts_sent,
    output logic [CNT_W-1:0] perf_pkts_suppressed,
    output logic [CNT_W-1:0] perf_stall_cycles
`endif
);

    typedef enum logic [2:0] {
        READY     = 3'd0,
        RD_REQ    = 3'd1,
        RD_RESP   = 3'd2,
        CALC      = 3'd3,
        DECIDE    = 3'd4,
        PKT_OUT   = 3'd5,
        WR_STATE  = 3'd6,
        SCHED_UPD = 3'd7
    } state_t;

    // Read channel bit order: 0 tail ptr, 1 tx state, 2 rx state, 3 tuple.
    state_t     state_r;
    logic       sched_rdy_r;
    logic [3:0] rd_val_r;
    logic [3:0] rd_done_r;
    logic       state_done_r;
    logic       tuple_done_r;
    logic       store_calc_r;
    logic       tx_pkt_val_r;
    logic       wr_val_r;
    logic       upd_val_r;

    logic [3:0] rd_rdy_s;
    logic [3:0] rd_hs_s;
    logic       rd_all_s;
    logic       accept_s;
    logic       in_resp_s;
    logic       state_fire_s;
    logic       tuple_fire_s;
    logic       resp_exit_s;

    // A zero CNT_W would make the perf counters meaningless.
    if (CNT_W < 1) begin : g_cnt_w_guard
    end

    assign rd_rdy_s = {tuple_rd_req_rdy, rx_state_rd_req_rdy,
                       curr_tx_state_rd_req_rdy, tail_ptr_rd_req_rdy};
    assign rd_hs_s  = rd_val_r & rd_rdy_s;
    // A grant seen this cycle counts as done for the exit decision.
    assign rd_all_s = &(rd_done_r | rd_hs_s);

    // Handshake-qualified strobes are gated by rst so nothing fires in reset.
    assign accept_s     = rst & sched_rdy_r & sched_tx_req_val;
    assign in_resp_s    = rst & (state_r == RD_RESP);
    // The three state responses are consumed only as a simultaneous join.
    assign state_fire_s = in_resp_s & ~state_done_r & tail_ptr_rd_resp_val
                        & curr_tx_state_rd_resp_val & rx_state_rd_resp_val;
    assign tuple_fire_s = in_resp_s & ~tuple_done_r & tuple_rd_resp_val;
    assign resp_exit_s  = (state_done_r | state_fire_s) & (tuple_done_r | tuple_fire_s);

    // Flow sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= READY;
            sched_rdy_r  <= 1'b0;
            rd_val_r     <= 4'b0000;
            rd_done_r    <= 4'b0000;
            state_done_r <= 1'b0;
            tuple_done_r <= 1'b0;
            store_calc_r <= 1'b0;
            tx_pkt_val_r <= 1'b0;
            wr_val_r     <= 1'b0;
            upd_val_r    <= 1'b0;
        end else begin
            case (state_r)
                READY: begin
                    if (accept_s) begin
                        sched_rdy_r <= 1'b0;
                        rd_val_r    <= 4'b1111;
                        rd_done_r   <= 4'b0000;
                        state_r     <= RD_REQ;
                    end else begin
                        sched_rdy_r <= 1'b1;
                    end
                end
                RD_REQ: begin
                    // Each request drops the cycle after its own grant.
                    rd_val_r <= rd_val_r & ~rd_rdy_s;
                    if (rd_all_s) begin
                        rd_done_r    <= 4'b0000;
                        state_done_r <= 1'b0;
                        tuple_done_r <= 1'b0;
                        state_r      <= RD_RESP;
                    end else begin
                        rd_done_r <= rd_done_r | rd_hs_s;
                    end
                end
                RD_RESP: begin
                    if (resp_exit_s) begin
                        state_done_r <= 1'b0;
                        tuple_done_r <= 1'b0;
                        store_calc_r <= 1'b1;
                        state_r      <= CALC;
                    end else begin
                        state_done_r <= state_done_r | state_fire_s;
                        tuple_done_r <= tuple_done_r | tuple_fire_s;
                    end
                end
                CALC: begin
                    store_calc_r <= 1'b0;
                    state_r      <= DECIDE;
                end
                DECIDE: begin
                    // No packet means sequence state is unchanged: skip writeback.
                    if (datap_ctrl_produce_pkt) begin
                        tx_pkt_val_r <= 1'b1;
                        state_r      <= PKT_OUT;
                    end else begin
                        upd_val_r <= 1'b1;
                        state_r   <= SCHED_UPD;
                    end
                end
                PKT_OUT: begin
                    if (tx_pkt_rdy) begin
                        tx_pkt_val_r <= 1'b0;
                        wr_val_r     <= 1'b1;
                        state_r      <= WR_STATE;
                    end else begin
                        tx_pkt_val_r <= 1'b1;
                    end
                end
                WR_STATE: begin
                    if (next_tx_state_wr_req_rdy) begin
                        wr_val_r  <= 1'b0;
                        upd_val_r <= 1'b1;
                        state_r   <= SCHED_UPD;
                    end else begin
                        wr_val_r <= 1'b1;
                    end
                end
                SCHED_UPD: begin
                    if (sched_tx_update_rdy) begin
                        upd_val_r   <= 1'b0;
                        sched_rdy_r <= 1'b1;
                        state_r     <= READY;
                    end else begin
                        upd_val_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= READY;
                    sched_rdy_r  <= 1'b0;
                    rd_val_r     <= 4'b0000;
                    rd_done_r    <= 4'b0000;
                    state_done_r <= 1'b0;
                    tuple_done_r <= 1'b0;
                    store_calc_r <= 1'b0;
                    tx_pkt_val_r <= 1'b0;
                    wr_val_r     <= 1'b0;
                    upd_val_r    <= 1'b0;
                end
            endcase
        end
    end

    assign sched_tx_req_rdy          = sched_rdy_r;
    assign tail_ptr_rd_req_val       = rd_val_r[0];
    assign curr_tx_state_rd_req_val  = rd_val_r[1];
    assign rx_state_rd_req_val       = rd_val_r[2];
    assign tuple_rd_req_val          = rd_val_r[3];
    assign tail_ptr_rd_resp_rdy      = state_fire_s;
    assign curr_tx_state_rd_resp_rdy = state_fire_s;
    assign rx_state_rd_resp_rdy      = state_fire_s;
    assign tuple_rd_resp_rdy         = tuple_fire_s;
    assign next_tx_state_wr_req_val  = wr_val_r;
    assign tx_pkt_val                = tx_pkt_val_r;
    assign sched_tx_update_val       = upd_val_r;
    assign ctrl_datap_store_flowid   = accept_s;
    assign ctrl_datap_store_state    = state_fire_s;
    assign ctrl_datap_store_tuple    = tuple_fire_s;
    assign ctrl_datap_store_calc     = store_calc_r;

`ifdef TCP_TX_CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] sent_r;
    logic [CNT_W-1:0] supp_r;
    logic [CNT_W-1:0] stall_r;
    logic             stall_s;

    // One stall tick per cycle, however many valids are waiting.
    assign stall_s = (|(rd_val_r & ~rd_rdy_s))
                   | (tx_pkt_val_r & ~tx_pkt_rdy)
                   | (wr_val_r & ~next_tx_state_wr_req_rdy)
                   | (upd_val_r & ~sched_tx_update_rdy);

    // Wrapping performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sent_r  <= {CNT_W{1'b0}};
            supp_r  <= {CNT_W{1'b0}};
            stall_r <= {CNT_W{1'b0}};
        end else begin
            if (tx_pkt_val_r && tx_pkt_rdy) begin
                sent_r <= sent_r + CNT_ONE;
            end else begin
                sent_r <= sent_r;
            end
            if ((state_r == DECIDE) && !datap_ctrl_produce_pkt) begin
                supp_r <= supp_r + CNT_ONE;
            end else begin
                supp_r <= supp_r;
            end
            if (stall_s) begin
                stall_r <= stall_r + CNT_ONE;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

    assign perf_pkts_sent       = sent_r;
    assign perf_pkts_suppressed = supp_r;
    assign perf_stall_cycles    = stall_r;
`endif

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tcp_tx_ctrl
//
// Directed cycle-exact scenarios for the flow timeline, join behaviour,
// backpressure and mid-flow reset, followed by a randomized phase where the
// memories, packet builder and scheduler respond with random delays. The
// random phase is checked by a per-flow event scoreboard: each flow must see
// exactly one of each datapath strobe and grant, the packet/writeback only
// when the datapath asked for a packet, and strict event ordering.
// -----------------------------------------------------------------------------
module tb_tcp_tx_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sched_val;
    logic       produce;
    logic [3:0] rd_rdy;
    logic [3:0] resp_val;
    logic       pkt_rdy, wr_rdy, upd_rdy;

    logic       sched_rdy;
    logic [3:0] rd_val;
    logic [3:0] resp_rdy;
    logic       pkt_val, wr_val, upd_val;
    logic       st_flowid, st_state, st_tuple, st_calc;
`ifdef TCP_TX_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] perf_sent, perf_supp, perf_stall;
`endif

    tcp_tx_ctrl #(.CNT_W(CNT_W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .sched_tx_req_val          (sched_val),
        .sched_tx_req_rdy          (sched_rdy),
        .tail_ptr_rd_req_val       (rd_val[0]),
        .tail_ptr_rd_req_rdy       (rd_rdy[0]),
        .tail_ptr_rd_resp_val      (resp_val[0]),
        .tail_ptr_rd_resp_rdy      (resp_rdy[0]),
        .curr_tx_state_rd_req_val  (rd_val[1]),
        .curr_tx_state_rd_req_rdy  (rd_rdy[1]),
        .curr_tx_state_rd_resp_val (resp_val[1]),
        .curr_tx_state_rd_resp_rdy (resp_rdy[1]),
        .rx_state_rd_req_val       (rd_val[2]),
        .rx_state_rd_req_rdy       (rd_rdy[2]),
        .rx_state_rd_resp_val      (resp_val[2]),
        .rx_state_rd_resp_rdy      (resp_rdy[2]),
        .tuple_rd_req_val          (rd_val[3]),
        .tuple_rd_req_rdy          (rd_rdy[3]),
        .tuple_rd_resp_val         (resp_val[3]),
        .tuple_rd_resp_rdy         (resp_rdy[3]),
        .next_tx_state_wr_req_val  (wr_val),
        .next_tx_state_wr_req_rdy  (wr_rdy),
        .tx_pkt_val                (pkt_val),
        .tx_pkt_rdy                (pkt_rdy),
        .sched_tx_update_val       (upd_val),
        .sched_tx_update_rdy       (upd_rdy),
        .ctrl_datap_store_flowid   (st_flowid),
        .ctrl_datap_store_state    (st_state),
        .ctrl_datap_store_tuple    (st_tuple),
        .ctrl_datap_store_calc     (st_calc),
        .datap_ctrl_produce_pkt    (produce)
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        ,
        .perf_pkts_sent            (perf_sent),
        .perf_pkts_suppressed      (perf_supp),
        .perf_stall_cycles         (perf_stall)
`endif
    );

    logic [15:0] outs;
    logic [11:0] key;
    assign outs = {sched_rdy, rd_val, resp_rdy, pkt_val, wr_val, upd_val,
                   st_flowid, st_state, st_tuple, st_calc};
    // [11]rdy [10]flowid [9:6]rd_val [5]state [4]tuple [3]calc [2]pkt [1]wr [0]upd
    assign key = {sched_rdy, st_flowid, rd_val, st_state, st_tuple, st_calc,
                  pkt_val, wr_val, upd_val};

    int checks = 0;
    int errors = 0;

    // Random-phase scoreboard state
    int         g[4];
    int         dly[4];
    logic [3:0] pend;
    int         n_state, n_tuple, n_calc, n_pkt, n_wr;
    int         in_flight, flows_done;
    logic       exp_prod;
    logic [6:0] prev_hold;
    int         m_sent, m_supp, m_stall;
    logic       sched_val_n, produce_n, pkt_rdy_n, wr_rdy_n, upd_rdy_n;
    logic [3:0] rd_rdy_n, resp_val_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic all_ready();
        rd_rdy   = 4'hF;
        resp_val = 4'hF;
        pkt_rdy  = 1'b1;
        wr_rdy   = 1'b1;
        upd_rdy  = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        look();
        while (sched_rdy !== 1'b1 && n < 60) begin
            tick();
            look();
            n++;
        end
        chk(tag, sched_rdy, 1'b1);
    endtask

    // Expected key outputs k cycles after acceptance with every rdy/resp immediate.
    function automatic logic [11:0] exp_nominal(input int k, input logic prod);
        logic [11:0] v;
        v = 12'h000;
        case (k)
            0: v = 12'b1100_0000_0000;
            1: v = 12'b0011_1100_0000;
            2: v = 12'b0000_0011_0000;
            3: v = 12'b0000_0000_1000;
            4: v = 12'b0000_0000_0000;
            5: v = prod ? 12'b0000_0000_0100 : 12'b0000_0000_0001;
            6: v = prod ? 12'b0000_0000_0010 : 12'b1000_0000_0000;
            7: v = prod ? 12'b0000_0000_0001 : 12'b1000_0000_0000;
            default: v = 12'b1000_0000_0000;
        endcase
        return v;
    endfunction

    task automatic run_nominal(input logic prod, input string tag);
        produce = prod;
        for (int k = 0; k <= 8; k++) begin
            tick();
            sched_val = (k == 0);
            look();
            chk($sformatf("%s_k%0d", tag, k), key, exp_nominal(k, prod));
            chk($sformatf("%s_resp_rdy_k%0d", tag, k), resp_rdy, (k == 2) ? 4'hF : 4'h0);
        end
    endtask

    // Scoreboard update from the outputs/inputs of the current cycle.
    task automatic monitor();
        logic [6:0] vals, rdys;
        vals = {rd_val, pkt_val, wr_val, upd_val};
        rdys = {rd_rdy, pkt_rdy, wr_rdy, upd_rdy};
        if (prev_hold != 7'h00) chk("rnd_val_hold", vals & prev_hold, prev_hold);
        prev_hold = vals & ~rdys;
        if (prev_hold != 7'h00) m_stall++;

        if (in_flight != 0) chk("rnd_rdy_low_in_flight", sched_rdy, 1'b0);
        if (st_flowid) begin
            chk("rnd_one_flow", in_flight, 0);
            chk("rnd_flowid_hs", {sched_val, sched_rdy}, 2'b11);
            in_flight = 1;
            for (int i = 0; i < 4; i++) g[i] = 0;
            n_state = 0; n_tuple = 0; n_calc = 0; n_pkt = 0; n_wr = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (rd_val[i] && rd_rdy[i]) begin
                g[i]++;
                pend[i] = 1'b1;
                dly[i]  = $urandom_range(0, 3);
            end
        end
        if (resp_rdy[2:0] != 3'b000) chk("rnd_rdy_only_on_join", st_state, 1'b1);
        if (st_state) begin
            chk("rnd_join", {resp_val[2:0], resp_rdy[2:0]}, 6'h3F);
            chk("rnd_grants_before_state", g[0] + g[1] + g[2] + g[3], 4);
            n_state++;
        end
        if (st_tuple) begin
            chk("rnd_tuple_hs", {resp_val[3], resp_rdy[3]}, 2'b11);
            n_tuple++;
        end
        if (st_calc) begin
            chk("rnd_calc_after_state", n_state, 1);
            chk("rnd_calc_after_tuple", n_tuple, 1);
            n_calc++;
        end
        if (pkt_val && pkt_rdy) begin
            chk("rnd_pkt_after_calc", n_calc, 1);
            chk("rnd_pkt_wanted", exp_prod, 1'b1);
            n_pkt++;
            m_sent++;
        end
        if (wr_val && wr_rdy) begin
            chk("rnd_wr_after_pkt", n_pkt, 1);
            n_wr++;
        end
        if (upd_val && upd_rdy) begin
            chk("rnd_upd_pkts", n_pkt, int'(exp_prod));
            chk("rnd_upd_wr", n_wr, int'(exp_prod));
            chk("rnd_upd_calc", n_calc, 1);
            chk("rnd_upd_stores", {n_state == 1, n_tuple == 1}, 2'b11);
            chk("rnd_upd_grants", {g[3] == 1, g[2] == 1, g[1] == 1, g[0] == 1}, 4'hF);
            if (!exp_prod) m_supp++;
            in_flight = 0;
            flows_done++;
        end
    endtask

    initial begin
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        logic [CNT_W-1:0] base_stall, base_sent, base_supp;
`endif
        int st_pulses;

        // Reset
        rst = 1'b0;
        sched_val = 1'b0;
        produce = 1'b1;
        all_ready();
        repeat (3) tick();
        look();
        chk("reset_outs", outs, 16'h0000);
        tick();
        rst = 1'b1;
        wait_ready("t1_ready_after_reset");

        // Nominal flow with a packet, then one without
        run_nominal(1'b1, "t1");
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        chk("t1_perf_sent", perf_sent, 1);
        chk("t1_perf_stall", perf_stall, 0);
`endif
        wait_ready("t2_ready");
        run_nominal(1'b0, "t2");
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        chk("t2_perf_supp", perf_supp, 1);
        chk("t2_perf_sent", perf_sent, 1);
`endif

        // rx-state response three cycles late
        wait_ready("t3_ready");
        produce = 1'b1;
        st_pulses = 0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            sched_val   = (k == 0);
            resp_val[2] = (k >= 5);
            look();
            if (st_state) st_pulses++;
            chk($sformatf("t3_store_state_k%0d", k), st_state, k == 5);
            chk($sformatf("t3_state_rdys_k%0d", k), resp_rdy[2:0], (k == 5) ? 3'b111 : 3'b000);
            chk($sformatf("t3_store_tuple_k%0d", k), st_tuple, k == 2);
            chk($sformatf("t3_calc_k%0d", k), st_calc, k == 6);
        end
        chk("t3_state_pulses", st_pulses, 1);

        // tuple read grant held off four cycles
        wait_ready("t4_ready");
        all_ready();
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        base_stall = perf_stall;
`endif
        for (int k = 0; k <= 6; k++) begin
            tick();
            sched_val = (k == 0);
            rd_rdy[3] = !(k >= 1 && k <= 4);
            look();
            chk($sformatf("t4_rd_val_k%0d", k), rd_val,
                (k == 1) ? 4'hF : ((k >= 2 && k <= 5) ? 4'h8 : 4'h0));
            chk($sformatf("t4_resp_k%0d", k), {st_state, st_tuple}, (k == 6) ? 2'b11 : 2'b00);
        end
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        chk("t4_perf_stall", perf_stall - base_stall, 4);
`endif

        // Packet builder backpressure for ten cycles
        wait_ready("t5_ready");
        all_ready();
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        base_stall = perf_stall;
`endif
        for (int k = 0; k <= 16; k++) begin
            tick();
            sched_val = (k == 0);
            pkt_rdy   = !(k >= 5 && k <= 14);
            look();
            chk($sformatf("t5_pkt_val_k%0d", k), pkt_val, k >= 5 && k <= 15);
            chk($sformatf("t5_wr_val_k%0d", k), wr_val, k == 16);
        end
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        chk("t5_perf_stall", perf_stall - base_stall, 10);
`endif

        // Reset in the middle of PKT_OUT
        wait_ready("t6_ready");
        all_ready();
        for (int k = 0; k <= 7; k++) begin
            tick();
            sched_val = (k == 0);
            pkt_rdy   = 1'b0;
            if (k == 6) rst = 1'b0;
            look();
            if (k == 5) chk("t6_in_pkt_out", pkt_val, 1'b1);
        end
        chk("t6_reset_outs", outs, 16'h0000);
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        chk("t6_perf_clear", {perf_sent, perf_supp, perf_stall}, 96'h0);
`endif
        tick();
        rst = 1'b1;
        all_ready();
        tick();
        look();
        chk("t6_rdy_after_release", sched_rdy, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            look();
            chk($sformatf("t6_no_stale_k%0d", k), {pkt_val, wr_val, upd_val, rd_val}, 7'h00);
        end

        // Randomized phase
        resp_val = 4'h0;
        pend = 4'h0;
        in_flight = 0;
        flows_done = 0;
        prev_hold = 7'h00;
        m_sent = 0; m_supp = 0; m_stall = 0;
        exp_prod = 1'b0;
        produce_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g[i] = 0;
            dly[i] = 0;
        end
        n_state = 0; n_tuple = 0; n_calc = 0; n_pkt = 0; n_wr = 0;
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        base_sent  = perf_sent;
        base_supp  = perf_supp;
        base_stall = perf_stall;
`endif
        for (int cyc = 0; cyc < 700; cyc++) begin
            look();
            monitor();
            resp_val_n = resp_val;
            for (int i = 0; i < 4; i++) begin
                if (resp_val[i] && resp_rdy[i]) begin
                    resp_val_n[i] = 1'b0;
                    pend[i] = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                rd_rdy_n[i] = 1'($urandom_range(0, 1));
                if (pend[i] && !resp_val_n[i]) begin
                    if (dly[i] == 0) resp_val_n[i] = 1'b1;
                    else dly[i]--;
                end
            end
            pkt_rdy_n = ($urandom_range(0, 2) != 0);
            wr_rdy_n  = ($urandom_range(0, 2) != 0);
            upd_rdy_n = ($urandom_range(0, 2) != 0);
            sched_val_n = (cyc < 500) && ((sched_val && !sched_rdy) || ($urandom_range(0, 3) == 0));
            if (st_flowid) begin
                produce_n = 1'($urandom_range(0, 1));
                exp_prod  = produce_n;
            end
            tick();
            sched_val = sched_val_n;
            produce   = produce_n;
            rd_rdy    = rd_rdy_n;
            resp_val  = resp_val_n;
            pkt_rdy   = pkt_rdy_n;
            wr_rdy    = wr_rdy_n;
            upd_rdy   = upd_rdy_n;
        end
        chk("rnd_drained", in_flight, 0);
        chk("rnd_enough_flows", flows_done >= 5, 1'b1);
`ifdef TCP_TX_CTRL_PERF_CNT_EN
        look();
        chk("rnd_perf_sent", perf_sent - base_sent, m_sent);
        chk("rnd_perf_supp", perf_supp - base_supp, m_supp);
        chk("rnd_perf_stall", perf_stall - base_stall, m_stall);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
